// File: rtl/ibex_prefetch_buffer_mq.sv
// Instruction prefetch buffer: multiple outstanding bus requests, word FIFO, counter-based flush.
// Optional IBEX_PREFETCH_STATS_EN adds saturating discard/stall statistics ports.
module ibex_prefetch_buffer_mq #(
  parameter int unsigned NumReqs   = 2,
  parameter int unsigned FifoDepth = 3,
  parameter bit          ResetAll  = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        instr_rvalid_i,
  output logic        busy_o
`ifdef IBEX_PREFETCH_STATS_EN
  ,
  output logic [15:0] stat_discard_o,
  output logic [15:0] stat_stall_o
`endif
);

  localparam int unsigned CW = $clog2(NumReqs + 1);
  localparam int unsigned FW = $clog2(FifoDepth + 1);
  localparam int unsigned PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  logic [CW-1:0] outs_q, outs_d, disc_q, disc_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic          held_q, held_d, stale_q, stale_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   held_addr_q, held_addr_d;
  logic [31:0]   push_addr_q, push_addr_d;
  entry_t [FifoDepth-1:0] fifo_q, fifo_d;

  logic [31:0] addr_al;
  logic        credit_ok, new_req, fresh_issue, gnt, drop, push, pop;
  entry_t      head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == FifoDepth - 1) ? '0 : p + 1'b1;
  endfunction

  assign addr_al = addr_i & 32'hFFFF_FFFC;

  // Outstanding requests that will still land count against FIFO space; a branch empties it.
  assign credit_ok   = branch_i | ((32'(cnt_q) + 32'(outs_q)) < FifoDepth);
  assign new_req     = req_i & (32'(outs_q) < NumReqs) & credit_ok;
  assign instr_req_o = held_q | new_req;
  assign fresh_issue = new_req & ~held_q;
  assign instr_addr_o = held_q ? held_addr_q : (branch_i ? addr_al : fetch_addr_q);
  assign gnt         = instr_req_o & instr_gnt_i;

  // Responses arriving in a branch cycle, or while stale ones remain, belong to the old stream.
  assign drop = instr_rvalid_i & (branch_i | (disc_q != '0));
  assign push = instr_rvalid_i & ~drop;
  assign pop  = valid_o & ready_i & ~branch_i;

  assign head    = fifo_q[rd_ptr_q];
  assign valid_o = (cnt_q != '0);
  assign rdata_o = head.rdata;
  assign addr_o  = head.addr;
  assign err_o   = valid_o & head.err;
  assign busy_o  = instr_req_o | (outs_q != '0);

  always_comb begin
    outs_d       = outs_q + CW'(gnt) - CW'(instr_rvalid_i);
    disc_d       = disc_q;
    held_d       = instr_req_o & ~instr_gnt_i;
    stale_d      = held_d & held_q & (branch_i | stale_q);
    held_addr_d  = held_d ? instr_addr_o : held_addr_q;
    fetch_addr_d = fetch_addr_q;
    push_addr_d  = push_addr_q;
    fifo_d       = fifo_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;

    if (fresh_issue) begin
      fetch_addr_d = instr_addr_o + 32'd4;
    end else if (branch_i) begin
      fetch_addr_d = addr_al;
    end

    if (branch_i) begin
      // A held request granted now was issued before the redirect, so it is stale too.
      disc_d      = outs_q - CW'(instr_rvalid_i) + CW'(held_q & gnt);
      push_addr_d = addr_al;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      cnt_d       = '0;
    end else begin
      disc_d = disc_q - CW'(drop) + CW'(held_q & stale_q & gnt);
      if (push) begin
        fifo_d[wr_ptr_q] = {instr_rdata_i, push_addr_q, instr_err_i};
        wr_ptr_d         = ptr_inc(wr_ptr_q);
        push_addr_d      = push_addr_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      cnt_d = cnt_q + FW'(push) - FW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outs_q   <= '0;
      disc_q   <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      held_q   <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      outs_q   <= outs_d;
      disc_q   <= disc_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      held_q   <= held_d;
      stale_q  <= stale_d;
    end
  end

  if (ResetAll) begin : g_data_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        fetch_addr_q <= '0;
        held_addr_q  <= '0;
        push_addr_q  <= '0;
        fifo_q       <= '0;
      end else begin
        fetch_addr_q <= fetch_addr_d;
        held_addr_q  <= held_addr_d;
        push_addr_q  <= push_addr_d;
        fifo_q       <= fifo_d;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk_i) begin
      fetch_addr_q <= fetch_addr_d;
      held_addr_q  <= held_addr_d;
      push_addr_q  <= push_addr_d;
      fifo_q       <= fifo_d;
    end
  end

`ifdef IBEX_PREFETCH_STATS_EN
  logic stall;
  assign stall = req_i & ~instr_req_o & ~branch_i & (32'(outs_q) < NumReqs) & ~credit_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_discard_o <= '0;
      stat_stall_o   <= '0;
    end else begin
      if (drop && stat_discard_o != 16'hFFFF) stat_discard_o <= stat_discard_o + 16'd1;
      if (stall && stat_stall_o != 16'hFFFF) stat_stall_o <= stat_stall_o + 16'd1;
    end
  end
`endif

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(instr_rvalid_i && outs_q == '0));
      assert (!(push && !pop && 32'(cnt_q) == FifoDepth));
    end
  end

endmodule

// File: tb/tb_ibex_prefetch_buffer_mq.sv
// Directed bench for ibex_prefetch_buffer_mq (NumReqs=2, FifoDepth=3): hand-traced bus cycles.
module tb_ibex_prefetch_buffer_mq;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, branch_i, ready_i;
  logic [31:0] addr_i;
  logic        valid_o, err_o, instr_req_o, busy_o;
  logic [31:0] rdata_o, addr_o, instr_addr_o;
  logic        instr_gnt_i, instr_err_i, instr_rvalid_i;
  logic [31:0] instr_rdata_i;
`ifdef IBEX_PREFETCH_STATS_EN
  logic [15:0] stat_discard_o, stat_stall_o;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  ibex_prefetch_buffer_mq #(.NumReqs(2), .FifoDepth(3), .ResetAll(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i), .instr_rvalid_i(instr_rvalid_i),
    .busy_o(busy_o)
`ifdef IBEX_PREFETCH_STATS_EN
    , .stat_discard_o(stat_discard_o), .stat_stall_o(stat_stall_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive after the rising edge, return at the falling edge for checks.
  task automatic cyc(input logic req, input logic br, input logic [31:0] a, input logic g,
                     input logic rv, input logic [31:0] rd, input logic e, input logic rdy);
    @(posedge clk_i);
    #1;
    req_i = req; branch_i = br; addr_i = a; instr_gnt_i = g;
    instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = e; ready_i = rdy;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i = 0; branch_i = 0; addr_i = 0; ready_i = 0;
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0; instr_err_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_req", instr_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Branch to 0x200 with two requests outstanding: both responses dropped.
  task automatic branch_drop();
    cyc(1, 1, 32'h100, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 0, 0, 1);
    chk("t4_addr1", instr_addr_o, 32'h104);
    cyc(1, 1, 32'h200, 1, 0, 0, 0, 1);
    chk("t4_noreq_br", instr_req_o, 0);
    cyc(1, 0, 0, 0, 1, 32'hDEAD0, 0, 1);
    chk("t4_noreq", instr_req_o, 0);
    cyc(1, 0, 0, 1, 1, 32'hDEAD1, 0, 1);
    chk("t4_addr200", instr_addr_o, 32'h200);
    chk("t4_v_drop", valid_o, 0);
    cyc(0, 0, 0, 0, 1, 32'hC0, 0, 1);
    chk("t4_v_drop2", valid_o, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t4_valid", valid_o, 1);
    chk("t4_addr_o", addr_o, 32'h200);
    chk("t4_rdata", rdata_o, 32'hC0);
  endtask

  initial begin
    // Sequential stream with gnt+rvalid every cycle.
    do_reset();
    cyc(1, 1, 32'h100, 1, 0, 0, 0, 1);
    chk("t1_req", instr_req_o, 1);
    chk("t1_addr0", instr_addr_o, 32'h100);
    chk("t1_v0", valid_o, 0);
    cyc(1, 0, 0, 1, 1, 32'hA0, 0, 1);
    chk("t1_addr1", instr_addr_o, 32'h104);
    chk("t1_busy", busy_o, 1);
    cyc(1, 0, 0, 1, 1, 32'hA1, 1, 1);
    chk("t1_addr2", instr_addr_o, 32'h108);
    chk("t1_o0_addr", addr_o, 32'h100);
    chk("t1_o0_data", rdata_o, 32'hA0);
    chk("t1_o0_err", err_o, 0);
    cyc(0, 0, 0, 0, 1, 32'hA2, 0, 1);
    chk("t1_req_off", instr_req_o, 0);
    chk("t1_o1_addr", addr_o, 32'h104);
    chk("t1_o1_data", rdata_o, 32'hA1);
    chk("t1_o1_err", err_o, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t1_o2_addr", addr_o, 32'h108);
    chk("t1_o2_data", rdata_o, 32'hA2);
    chk("t1_idle_busy", busy_o, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t1_empty", valid_o, 0);

    // Outstanding limit: two grants, then no request until an rvalid.
    do_reset();
    cyc(1, 1, 32'h100, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 0, 0, 1);
    chk("t2_req2", instr_req_o, 1);
    cyc(1, 0, 0, 1, 0, 0, 0, 1);
    chk("t2_limit_a", instr_req_o, 0);
    chk("t2_busy", busy_o, 1);
    cyc(1, 0, 0, 1, 0, 0, 0, 1);
    chk("t2_limit_b", instr_req_o, 0);
    cyc(1, 0, 0, 0, 1, 32'hB0, 0, 1);
    chk("t2_limit_c", instr_req_o, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("t2_req3", instr_req_o, 1);
    chk("t2_addr3", instr_addr_o, 32'h108);
    chk("t2_o_addr", addr_o, 32'h100);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t2_held_req", instr_req_o, 1);
    chk("t2_held_addr", instr_addr_o, 32'h108);
    chk("t2_popped", valid_o, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 1);
    chk("t2_held_gnt", instr_req_o, 1);

    // FIFO full with ready low, then drain.
    do_reset();
    cyc(1, 1, 32'h100, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 32'hD0, 0, 0);
    cyc(1, 0, 0, 1, 1, 32'hD1, 0, 0);
    chk("t3_req3", instr_req_o, 1);
    cyc(1, 0, 0, 0, 1, 32'hD2, 0, 0);
    chk("t3_credit_a", instr_req_o, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_credit_b", instr_req_o, 0);
    chk("t3_head", addr_o, 32'h100);
    chk("t3_busy", busy_o, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("t3_credit_c", instr_req_o, 0);
    chk("t3_d0", rdata_o, 32'hD0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t3_d1_addr", addr_o, 32'h104);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t3_d2_addr", addr_o, 32'h108);
    chk("t3_d2", rdata_o, 32'hD2);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t3_empty", valid_o, 0);

    do_reset();
    branch_drop();
`ifdef IBEX_PREFETCH_STATS_EN
    branch_drop();
    branch_drop();
    chk("stat_discard", 32'(stat_discard_o), 6);
`endif

    // Branch while a request at 0x10C is held ungranted.
    do_reset();
    cyc(1, 1, 32'h100, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 1, 32'hE0, 0, 1);
    cyc(1, 0, 0, 1, 1, 32'hE1, 0, 1);
    cyc(1, 0, 0, 0, 1, 32'hE2, 0, 1);
    chk("t5_addr10c", instr_addr_o, 32'h10C);
    cyc(1, 1, 32'h200, 0, 0, 0, 0, 1);
    chk("t5_held_br", instr_addr_o, 32'h10C);
    chk("t5_held_req", instr_req_o, 1);
    cyc(1, 0, 0, 1, 0, 0, 0, 1);
    chk("t5_gnt10c", instr_addr_o, 32'h10C);
    chk("t5_flushed", valid_o, 0);
    cyc(1, 0, 0, 0, 1, 32'h5A1E, 0, 1);
    chk("t5_addr200", instr_addr_o, 32'h200);
    cyc(1, 0, 0, 1, 0, 0, 0, 1);
    chk("t5_dropped", valid_o, 0);
    chk("t5_hold200", instr_addr_o, 32'h200);
    cyc(0, 0, 0, 0, 1, 32'hF0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t5_valid", valid_o, 1);
    chk("t5_addr_o", addr_o, 32'h200);
    chk("t5_rdata", rdata_o, 32'hF0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
